// File: rtl/nn_pkg.sv
// Shared fixed-point defaults, limits and FSM encoding for the neural-network datapath blocks.
package nn_pkg;

    localparam int NN_DATA_WIDTH = 16;
    localparam int NN_FRAC_BITS  = 8;
    localparam int NN_ACC_WIDTH  = 40;

    localparam logic signed [NN_DATA_WIDTH-1:0] NN_FX_MAX = 16'sh7FFF;
    localparam logic signed [NN_DATA_WIDTH-1:0] NN_FX_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/fx_saturate.sv
// Combinational rescale of a wide accumulator (arithmetic shift by FRAC_BITS, floor rounding)
// followed by clamping into the signed DATA_WIDTH range.
module fx_saturate #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    output logic signed [DATA_WIDTH-1:0] data_o
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_EXT =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_EXT =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        shifted = acc_i >>> FRAC_BITS;
        if (shifted > MAX_EXT) begin
            data_o = MAX_EXT[DATA_WIDTH-1:0];
        end else if (shifted < MIN_EXT) begin
            data_o = MIN_EXT[DATA_WIDTH-1:0];
        end else begin
            data_o = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron MAC: one weight-ROM read per activation, accumulate, add bias, rescale, saturate.
// Optional NEURON_RELU_EN clamps negative results to zero before they are registered.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int FRAC_BITS  = NN_FRAC_BITS,
    parameter int ACC_WIDTH  = NN_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  w_r_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output state_t                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and the result stays stable until it is taken.
    state_t                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]  x_q, x_d;
    logic                          out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    bias_ext;
    logic signed [ACC_WIDTH-1:0]    sum;
    logic signed [DATA_WIDTH-1:0]   sat;
    logic [DATA_WIDTH-1:0]          result;
    logic                           last;

    assign in_ready  = (state_q == IDLE);
    assign w_r_en    = in_valid & in_ready;
    assign w_addr    = idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign dbg_state = state_q;

    // w_data is only meaningful in WAIT, one cycle after the read was issued.
    assign prod     = x_q * $signed(w_data);
    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){bias[DATA_WIDTH-1]}}, bias,
                       {FRAC_BITS{1'b0}}};
    assign sum      = acc_q + prod_ext + bias_ext;
    assign last     = (idx_q == ADDR_WIDTH'(NUM_INPUTS-1));

    fx_saturate #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat (
        .acc_i  (sum),
        .data_o (sat)
    );

`ifdef NEURON_RELU_EN
    assign result = sat[DATA_WIDTH-1] ? '0 : sat;
`else
    assign result = sat;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        x_d         = x_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (last) begin
                    out_data_d  = result;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = OUTPUT;
                end else begin
                    acc_d   = acc_q + prod_ext;
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Testbench for neuron_mac: directed and randomized vectors checked against a fixed-point reference.
module tb_neuron_mac;
    import nn_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [15:0] bias = '0;
    logic [1:0]  w_addr;
    logic        w_r_en;
    logic [15:0] w_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    state_t      dbg_state;

    int tests = 0;
    int fails = 0;

    logic [15:0] rom [4] = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
    logic [15:0] exp_q [$];

    neuron_mac dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bias      (bias),
        .w_addr    (w_addr),
        .w_r_en    (w_r_en),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dbg_state (dbg_state)
    );

    // clock / reset block and weight ROM with one-cycle read latency
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_r_en) w_data <= rom[w_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: exact real-number dot product in Q16, floor rescale, clamp
    function automatic logic [15:0] ref_out(input logic [15:0] x [4], input logic [15:0] b);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            s += longint'($signed(x[i])) * longint'($signed(rom[i]));
        end
        s += longint'($signed(b)) * 256;
        s = s >>> 8;
        if (s > longint'(NN_FX_MAX)) s = longint'(NN_FX_MAX);
        if (s < longint'(NN_FX_MIN)) s = longint'(NN_FX_MIN);
`ifdef NEURON_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[15:0];
    endfunction

    // driver: one activation, starting and ending on a falling edge
    task automatic send_one(input logic [15:0] x, input int idx, input bit gapped);
        int n;
        if (gapped) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                #1 check("w_r_en_gap", 32'(w_r_en), 32'd0);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = x;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("w_r_en_hs", 32'(w_r_en), 32'd1);
        check("w_addr", 32'(w_addr), 32'(idx));
        @(negedge clk);
        in_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data  = 16'($urandom);
        #1;
        check("in_ready_wait", 32'(in_ready), 32'd0);
        check("w_r_en_wait", 32'(w_r_en), 32'd0);
        check("out_valid_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_vector(input logic [15:0] x [4], input logic [15:0] b, input bit gapped);
        bias = b;
        exp_q.push_back(ref_out(x, b));
        for (int i = 0; i < 4; i++) send_one(x[i], i, gapped);
        check("out_valid_rise", 32'(out_valid), 32'd1);
        if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        if (out_ready) begin
            @(negedge clk);
            check("out_valid_drop", 32'(out_valid), 32'd0);
            check("in_ready_after", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [15:0] v [4];
        logic [15:0] held;

        // reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_w_r_en", 32'(w_r_en), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // basic vector
        v = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        check("basic_ref", 32'(ref_out(v, 16'h0000)), 32'h0280);
        run_vector(v, 16'h0000, 1'b0);

        // bias and negative result
        v = '{16'h0000, 16'h0000, 16'h0200, 16'h0000};
        run_vector(v, 16'h0080, 1'b0);

        // saturation, both rails
        v = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000};
        run_vector(v, 16'h7FFF, 1'b0);
        v = '{16'h0000, 16'h8000, 16'h0000, 16'h0000};
        run_vector(v, 16'h0000, 1'b0);

        // back-pressure: result held, inputs ignored
        out_ready = 1'b0;
        v = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        run_vector(v, 16'h0000, 1'b0);
        held = out_data;
        repeat (5) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_w_r_en", 32'(w_r_en), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(out_valid), 32'd0);
        v = '{16'h0000, 16'h0200, 16'h0100, 16'h0000};
        run_vector(v, 16'hFF80, 1'b0);

        // asynchronous reset mid-vector
        send_one(16'h0100, 0, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h0100;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        v = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        run_vector(v, 16'h0000, 1'b0);

        // gapped input: directed vectors again, then random ones
        run_vector(v, 16'h0000, 1'b1);
        v = '{16'h0000, 16'h0000, 16'h0200, 16'h0000};
        run_vector(v, 16'h0080, 1'b1);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) v[i] = 16'($urandom);
            run_vector(v, 16'($urandom), 1'b1);
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Single-neuron multiply-accumulate stage; sits directly downstream of the weight ROM, which it addresses and consumes.
- Accepts a stream of NUM_INPUTS signed fixed-point activations and issues one ROM read per activation.
- Multiplies each activation by the returned weight, accumulates, adds bias, then scales, saturates and emits one result per input vector over a valid/ready handshake.

Parameters:
- NUM_INPUTS, 4, activations (and weights) per neuron; ROM depth ≥ NUM_INPUTS.
- ADDR_WIDTH, 2, ROM address width; requires 2^ADDR_WIDTH ≥ NUM_INPUTS.
- DATA_WIDTH, 16, signed activation/weight/bias/output width (Q8.8 by default).
- FRAC_BITS, 8, fractional bits of the DATA_WIDTH format.
- ACC_WIDTH, 40, signed accumulator width; ≥ 2*DATA_WIDTH + clog2(NUM_INPUTS) + 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  activation valid.
- in_ready  out  1  block can accept an activation.
- in_data  in  DATA_WIDTH  signed activation, index implied by arrival order.
- bias  in  DATA_WIDTH  signed bias, same format; sampled when the last product is accumulated.
- w_addr  out  ADDR_WIDTH  ROM address.
- w_r_en  out  1  ROM read enable.
- w_data  in  DATA_WIDTH  ROM read data, valid exactly one cycle after w_r_en.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_WIDTH  signed saturated neuron output.

Behaviour:
- Reset (rst low, asynchronous, any state): state=IDLE, idx=0, acc=0, x_reg=0, out_valid=0, out_data=0. in_ready then reads 1 and w_r_en reads 0.
- States: IDLE (accept activation), WAIT (ROM latency/accumulate), OUTPUT (hold result).
- in_ready = (state==IDLE).
- w_r_en = in_valid & in_ready (combinational); w_addr = idx.
- IDLE, on handshake: x_reg <= in_data; go to WAIT.
- WAIT (always exactly one cycle):
  - prod = signed x_reg * signed w_data (2*DATA_WIDTH, 2*FRAC_BITS fraction).
  - If idx < NUM_INPUTS-1: acc <= acc + prod; idx <= idx+1; go to IDLE.
  - If idx == NUM_INPUTS-1:
    - sum = acc + prod + (sign-extended bias << FRAC_BITS);
    - out_data <= saturate(sum >>> FRAC_BITS) to signed DATA_WIDTH (arithmetic shift, truncation toward −inf);
    - out_valid <= 1; acc <= 0; idx <= 0; go to OUTPUT.
- Saturation bounds: max 2^(DATA_WIDTH-1)-1 (0x7FFF), min −2^(DATA_WIDTH-1) (0x8000).
- OUTPUT: out_valid and out_data held stable until out_valid & out_ready. On that edge out_valid <= 0 and state goes to IDLE. No new activation is accepted while a result is pending (back-pressure).
- Throughput: 2 cycles per activation minimum. out_valid rises on the 2nd rising edge after the last input handshake.
- Accumulator never wraps given the ACC_WIDTH rule; only the final narrowing saturates.
- A reset mid-vector discards partial sums; the next activation is treated as index 0.
- in_valid while in_ready=0 is ignored; in_data need not be held.

Optional Feature:
- NEURON_RELU_EN defined: a negative saturated result is replaced by 0 before registering out_data; positive values are unchanged.
- Undefined: out_data is the signed saturated value, negatives passed through.

Decomposition:
- Shared package nn_pkg holds:
  - DATA_WIDTH, FRAC_BITS, ACC_WIDTH defaults;
  - state enum (IDLE, WAIT, OUTPUT);
  - the fixed-point min/max constants.
- One natural sub-module: fx_saturate (combinational shift-by-FRAC_BITS and clamp from ACC_WIDTH to DATA_WIDTH), reusable by later layers.

Test Plan:
- All tests use a ROM loaded with weights {0x0100, 0x0200, 0xFF00, 0x0080} = {1, 2, −1, 0.5}.
- Basic vector: inputs 0x0100 ×4, bias 0, out_ready=1 → out_data=0x0280 (2.5). out_valid high one cycle, two edges after the 4th handshake. w_addr sequence 0,1,2,3, one per handshake.
- Bias and negative result: inputs {0, 0, 0x0200, 0}, bias 0x0080:
  - macro off → out_data=0xFE80 (−1.5);
  - NEURON_RELU_EN → 0x0000.
- Saturation: inputs 0x7FFF ×2 then 0 ×2, bias 0x7FFF → out_data=0x7FFF. Input 0x8000 at index 1, others 0 → 0x8000.
- Back-pressure: out_ready=0 for 5 cycles after out_valid:
  - out_data stable and in_ready=0 throughout;
  - in_valid pulses are ignored;
  - after out_ready=1 the next vector starts at w_addr=0.
- Async reset mid-vector: drop rst after 2 handshakes, without a clock edge → out_valid=0 and in_ready=1 immediately. A fresh basic vector then still yields 0x0280.
- Gapped input: in_valid toggled randomly between activations → same results as the back-to-back runs; each w_r_en pulse coincides with a handshake.
